// File: rtl/m2_block_scheduler_pkg.sv
// Shared decode-stage types for the IDCT block scheduler.
// Holds the scheduler state and SRAM-owner enums, the plane codes,
// the default block counts of a 320x240 frame and the index/bus widths.
package m2_block_scheduler_pkg;

    localparam int unsigned Y_COL_BLOCKS_DEF  = 40;
    localparam int unsigned UV_COL_BLOCKS_DEF = 20;
    localparam int unsigned ROW_BLOCKS_DEF    = 30;

    localparam int unsigned COL_W   = 6;
    localparam int unsigned ROW_W   = 5;
    localparam int unsigned PLANE_W = 2;
    localparam int unsigned K_W     = 12;
    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned DATA_W  = 16;

    localparam logic [PLANE_W-1:0] PLANE_Y = 2'd0;
    localparam logic [PLANE_W-1:0] PLANE_U = 2'd1;
    localparam logic [PLANE_W-1:0] PLANE_V = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_LAUNCH,
        ST_A_WAIT,
        ST_B_LAUNCH,
        ST_B_WAIT,
        ST_ADVANCE,
        ST_DONE
    } m2_sched_state_type;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_FETCH,
        OWNER_WRITE
    } sram_owner_type;

endpackage

// File: rtl/m2_block_scheduler_if.sv
// Handshake and SRAM bus bundle between the block scheduler and its engines.
// master: the scheduler (drives starts, indices, done, SRAM port).
// slave : the environment (drives frame start, finishes, engine SRAM requests).
interface m2_block_scheduler_if;
    import m2_block_scheduler_pkg::*;

    logic               start;
    logic               done;
    logic               fetch_start;
    logic               ct_start;
    logic               cs_start;
    logic               ws_start;
    logic               fetch_finish;
    logic               ct_finish;
    logic               cs_finish;
    logic               ws_finish;
    logic [COL_W-1:0]   fetch_col;
    logic [ROW_W-1:0]   fetch_row;
    logic [PLANE_W-1:0] fetch_plane;
    logic [COL_W-1:0]   ws_col;
    logic [ROW_W-1:0]   ws_row;
    logic [PLANE_W-1:0] ws_plane;
    logic [ADDR_W-1:0]  fetch_sram_address;
    logic               fetch_sram_we_n;
    logic [ADDR_W-1:0]  ws_sram_address;
    logic               ws_sram_we_n;
    logic [DATA_W-1:0]  ws_sram_write_data;
    logic [ADDR_W-1:0]  SRAM_address;
    logic               SRAM_we_n;
    logic [DATA_W-1:0]  SRAM_write_data;

    modport master (
        input  start, fetch_finish, ct_finish, cs_finish, ws_finish,
               fetch_sram_address, fetch_sram_we_n,
               ws_sram_address, ws_sram_we_n, ws_sram_write_data,
        output done, fetch_start, ct_start, cs_start, ws_start,
               fetch_col, fetch_row, fetch_plane, ws_col, ws_row, ws_plane,
               SRAM_address, SRAM_we_n, SRAM_write_data
    );

    modport slave (
        output start, fetch_finish, ct_finish, cs_finish, ws_finish,
               fetch_sram_address, fetch_sram_we_n,
               ws_sram_address, ws_sram_we_n, ws_sram_write_data,
        input  done, fetch_start, ct_start, cs_start, ws_start,
               fetch_col, fetch_row, fetch_plane, ws_col, ws_row, ws_plane,
               SRAM_address, SRAM_we_n, SRAM_write_data
    );

endinterface

// File: rtl/m2_block_scheduler_block_index_counter.sv
// Block position counter: col wraps at the plane width, then row wraps at
// ROWS, then the plane steps Y -> U -> V (and back to Y).
// Ports: clock, reset (async high), clear (return to block 0),
// advance (step one block), col/row/plane (current block).
module block_index_counter
    import m2_block_scheduler_pkg::*;
#(
    parameter int unsigned COL_WIDTH = COL_W,
    parameter int unsigned ROW_WIDTH = ROW_W,
    parameter int unsigned Y_COLS    = Y_COL_BLOCKS_DEF,
    parameter int unsigned UV_COLS   = UV_COL_BLOCKS_DEF,
    parameter int unsigned ROWS      = ROW_BLOCKS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 advance,
    output logic [COL_WIDTH-1:0] col,
    output logic [ROW_WIDTH-1:0] row,
    output logic [PLANE_W-1:0]   plane
);

    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(ROWS - 1);

    logic [COL_WIDTH-1:0] last_col;

    // Chroma planes are half the luma width.
    assign last_col = (plane == PLANE_Y) ? COL_WIDTH'(Y_COLS - 1) : COL_WIDTH'(UV_COLS - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col   <= '0;
            row   <= '0;
            plane <= PLANE_Y;
        end else if (clear) begin
            col   <= '0;
            row   <= '0;
            plane <= PLANE_Y;
        end else if (advance) begin
            if (col != last_col) begin
                col <= col + COL_WIDTH'(1);
            end else begin
                col <= '0;
                if (row != LAST_ROW) begin
                    row <= row + ROW_WIDTH'(1);
                end else begin
                    row <= '0;
                    if (plane == PLANE_Y)      plane <= PLANE_U;
                    else if (plane == PLANE_U) plane <= PLANE_V;
                    else                       plane <= PLANE_Y;
                end
            end
        end
    end

endmodule

// File: rtl/m2_block_scheduler.sv
// IDCT decode-stage sequencer. Runs N+1 slots per frame; phase A overlaps
// fetch(k) with compute S(k-1), phase B overlaps compute T(k) with write S(k-1).
// Owns the single SRAM port and muxes it between fetch and write engines.
// Ports: clock, reset (async high), bus (scheduler side of the handshake/SRAM bundle).
module m2_block_scheduler
    import m2_block_scheduler_pkg::*;
#(
    parameter int unsigned Y_COL_BLOCKS  = Y_COL_BLOCKS_DEF,
    parameter int unsigned UV_COL_BLOCKS = UV_COL_BLOCKS_DEF,
    parameter int unsigned ROW_BLOCKS    = ROW_BLOCKS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    m2_block_scheduler_if.master bus
);

    localparam int unsigned    N_BLOCKS = (Y_COL_BLOCKS + 2 * UV_COL_BLOCKS) * ROW_BLOCKS;
    localparam logic [K_W-1:0] LAST_K   = K_W'(N_BLOCKS);

    m2_sched_state_type state;
    sram_owner_type     owner;
    logic [K_W-1:0]     k;
    logic [K_W-1:0]     k_inc;
    logic               has_cur;    // block k exists (k < N)
    logic               has_prev;   // block k-1 exists (k >= 1)
    logic               flag_a;     // fetch in phase A, compute T in phase B
    logic               flag_b;     // compute S in phase A, write S in phase B
    logic               armed;      // finishes are sampled only from launch+2
    logic               fetch_start_q, ct_start_q, cs_start_q, ws_start_q, done_q;
    logic [COL_W-1:0]   fetch_col, ws_col_q;
    logic [ROW_W-1:0]   fetch_row, ws_row_q;
    logic [PLANE_W-1:0] fetch_plane, ws_plane_q;
    logic               idx_clear, idx_advance;

    assign k_inc       = k + K_W'(1);
    assign has_cur     = (k != LAST_K);
    assign has_prev    = (k != '0);
    assign idx_clear   = (state == ST_IDLE) && bus.start;
    assign idx_advance = (state == ST_ADVANCE) && has_cur;

    block_index_counter #(
        .COL_WIDTH (COL_W),
        .ROW_WIDTH (ROW_W),
        .Y_COLS    (Y_COL_BLOCKS),
        .UV_COLS   (UV_COL_BLOCKS),
        .ROWS      (ROW_BLOCKS)
    ) u_fetch_idx (
        .clock   (clock),
        .reset   (reset),
        .clear   (idx_clear),
        .advance (idx_advance),
        .col     (fetch_col),
        .row     (fetch_row),
        .plane   (fetch_plane)
    );

    // Sequencer: launch pulses and owner are set on entry to a launch state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner         <= OWNER_NONE;
            k             <= '0;
            flag_a        <= 1'b0;
            flag_b        <= 1'b0;
            armed         <= 1'b0;
            fetch_start_q <= 1'b0;
            ct_start_q    <= 1'b0;
            cs_start_q    <= 1'b0;
            ws_start_q    <= 1'b0;
            done_q        <= 1'b0;
            ws_col_q      <= '0;
            ws_row_q      <= '0;
            ws_plane_q    <= PLANE_Y;
        end else begin
            fetch_start_q <= 1'b0;
            ct_start_q    <= 1'b0;
            cs_start_q    <= 1'b0;
            ws_start_q    <= 1'b0;
            done_q        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        k             <= '0;
                        ws_col_q      <= '0;
                        ws_row_q      <= '0;
                        ws_plane_q    <= PLANE_Y;
                        fetch_start_q <= 1'b1;
                        flag_a        <= 1'b0;
                        flag_b        <= 1'b1;
                        armed         <= 1'b0;
                        owner         <= OWNER_FETCH;
                        state         <= ST_A_LAUNCH;
                    end
                end
                ST_A_LAUNCH: state <= ST_A_WAIT;
                ST_A_WAIT: begin
                    if (!armed) begin
                        armed <= 1'b1;
                    end else begin
                        if (bus.fetch_finish) begin
                            flag_a <= 1'b1;
                            owner  <= OWNER_NONE;
                        end
                        if (bus.cs_finish) flag_b <= 1'b1;
                    end
                    if (flag_a && flag_b) begin
                        ct_start_q <= has_cur;
                        ws_start_q <= has_prev;
                        flag_a     <= !has_cur;
                        flag_b     <= !has_prev;
                        armed      <= 1'b0;
                        if (has_prev) owner <= OWNER_WRITE;
                        else          owner <= OWNER_NONE;
                        state      <= ST_B_LAUNCH;
                    end
                end
                ST_B_LAUNCH: state <= ST_B_WAIT;
                ST_B_WAIT: begin
                    if (!armed) begin
                        armed <= 1'b1;
                    end else begin
                        if (bus.ct_finish) flag_a <= 1'b1;
                        if (bus.ws_finish) begin
                            flag_b <= 1'b1;
                            owner  <= OWNER_NONE;
                        end
                    end
                    if (flag_a && flag_b) begin
                        owner <= OWNER_NONE;
                        state <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    if (!has_cur) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        // ws side trails fetch by exactly one block.
                        k             <= k_inc;
                        ws_col_q      <= fetch_col;
                        ws_row_q      <= fetch_row;
                        ws_plane_q    <= fetch_plane;
                        fetch_start_q <= (k_inc != LAST_K);
                        cs_start_q    <= 1'b1;
                        flag_a        <= (k_inc == LAST_K);
                        flag_b        <= 1'b0;
                        armed         <= 1'b0;
                        if (k_inc != LAST_K) owner <= OWNER_FETCH;
                        else                 owner <= OWNER_NONE;
                        state         <= ST_A_LAUNCH;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.fetch_start = fetch_start_q;
    assign bus.ct_start    = ct_start_q;
    assign bus.cs_start    = cs_start_q;
    assign bus.ws_start    = ws_start_q;
    assign bus.done        = done_q;
    assign bus.fetch_col   = fetch_col;
    assign bus.fetch_row   = fetch_row;
    assign bus.fetch_plane = fetch_plane;
    assign bus.ws_col      = ws_col_q;
    assign bus.ws_row      = ws_row_q;
    assign bus.ws_plane    = ws_plane_q;

    // SRAM port mux; the fetch engine only reads, so its write data is zero.
    always_comb begin
        bus.SRAM_address    = '0;
        bus.SRAM_we_n       = 1'b1;
        bus.SRAM_write_data = '0;
        case (owner)
            OWNER_FETCH: begin
                bus.SRAM_address = bus.fetch_sram_address;
                bus.SRAM_we_n    = bus.fetch_sram_we_n;
            end
            OWNER_WRITE: begin
                bus.SRAM_address    = bus.ws_sram_address;
                bus.SRAM_we_n       = bus.ws_sram_we_n;
                bus.SRAM_write_data = bus.ws_sram_write_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Directed bench for m2_block_scheduler on a 4-block frame
// (Y 2 cols, U/V 1 col, 1 row) with delay-programmable engine models.
module tb_m2_block_scheduler;
    import m2_block_scheduler_pkg::*;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    m2_block_scheduler_if ifc ();

    m2_block_scheduler #(
        .Y_COL_BLOCKS  (2),
        .UV_COL_BLOCKS (1),
        .ROW_BLOCKS    (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Engine models: index 0=fetch, 1=ct, 2=cs, 3=ws; finish pulses dly cycles after start.
    int         eng_dly [4];
    int         eng_cnt [4];
    logic [3:0] eng_force;
    logic [3:0] eng_start;
    assign eng_start = {ifc.ws_start, ifc.cs_start, ifc.ct_start, ifc.fetch_start};

    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < 4; i++) begin
            if (reset)                eng_cnt[i] <= 0;
            else if (eng_start[i])    eng_cnt[i] <= eng_dly[i];
            else if (eng_cnt[i] != 0) eng_cnt[i] <= eng_cnt[i] - 1;
        end
    end

    assign ifc.fetch_finish = (eng_cnt[0] == 1) | eng_force[0];
    assign ifc.ct_finish    = (eng_cnt[1] == 1) | eng_force[1];
    assign ifc.cs_finish    = (eng_cnt[2] == 1) | eng_force[2];
    assign ifc.ws_finish    = (eng_cnt[3] == 1) | eng_force[3];

    // Pulse log, sampled on the falling edge.
    int          fs_cyc[$], ct_cyc[$], cs_cyc[$], ws_cyc[$], done_cyc[$];
    logic [12:0] fs_idx[$], ws_idx[$];

    always @(negedge clock) begin
        if (!reset) begin
            if (ifc.fetch_start) begin
                fs_cyc.push_back(cyc);
                fs_idx.push_back({ifc.fetch_plane, ifc.fetch_row, ifc.fetch_col});
            end
            if (ifc.ws_start) begin
                ws_cyc.push_back(cyc);
                ws_idx.push_back({ifc.ws_plane, ifc.ws_row, ifc.ws_col});
            end
            if (ifc.ct_start) ct_cyc.push_back(cyc);
            if (ifc.cs_start) cs_cyc.push_back(cyc);
            if (ifc.done)     done_cyc.push_back(cyc);
        end
    end

    function automatic logic [12:0] exp_idx(input int i);
        case (i)
            0:       return 13'h0000;  // (0,0,Y)
            1:       return 13'h0001;  // (1,0,Y)
            2:       return 13'h0800;  // (0,0,U)
            3:       return 13'h1000;  // (0,0,V)
            default: return 13'h1fff;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        fs_cyc.delete(); ct_cyc.delete(); cs_cyc.delete(); ws_cyc.delete();
        done_cyc.delete(); fs_idx.delete(); ws_idx.delete();
    endtask

    task automatic idle_inputs();
        ifc.fetch_sram_address = '0;
        ifc.fetch_sram_we_n    = 1'b1;
        ifc.ws_sram_address    = '0;
        ifc.ws_sram_we_n       = 1'b1;
        ifc.ws_sram_write_data = '0;
    endtask

    // Start high for one cycle; c = label of that cycle.
    task automatic pulse_start(output int c);
        ifc.start = 1'b1;
        c = cyc;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input int want);
        int n = 0;
        while (done_cyc.size() < want && n < 2000) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic test_reset();
        ifc.fetch_sram_address = 18'h3ffff;
        ifc.fetch_sram_we_n    = 1'b0;
        ifc.ws_sram_address    = 18'h12345;
        ifc.ws_sram_we_n       = 1'b0;
        ifc.ws_sram_write_data = 16'hffff;
        repeat (3) tick();
        total++;
        if ({ifc.fetch_start, ifc.ct_start, ifc.cs_start, ifc.ws_start, ifc.done} !== 5'b0) begin
            bad++; $display("FAIL reset_pulses: got %b want 00000",
                {ifc.fetch_start, ifc.ct_start, ifc.cs_start, ifc.ws_start, ifc.done});
        end
        total++;
        if ({ifc.fetch_plane, ifc.fetch_row, ifc.fetch_col, ifc.ws_plane, ifc.ws_row, ifc.ws_col} !== 26'h0) begin
            bad++; $display("FAIL reset_indices: got fetch %h ws %h want 0",
                {ifc.fetch_plane, ifc.fetch_row, ifc.fetch_col}, {ifc.ws_plane, ifc.ws_row, ifc.ws_col});
        end
        total++;
        if ({ifc.SRAM_we_n, ifc.SRAM_address, ifc.SRAM_write_data} !== {1'b1, 18'h0, 16'h0}) begin
            bad++; $display("FAIL reset_sram: got we_n=%b addr=%h data=%h want 1/0/0",
                ifc.SRAM_we_n, ifc.SRAM_address, ifc.SRAM_write_data);
        end
        total++;
        if (dut.state !== ST_IDLE) begin
            bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, ST_IDLE);
        end
        reset = 1'b0;
        tick();
        idle_inputs();
        total++;
        if (ifc.fetch_start !== 1'b0) begin
            bad++; $display("FAIL reset_no_spurious_start: got %b want 0", ifc.fetch_start);
        end
    endtask

    task automatic test_frame();
        int c;
        int dummy;
        clear_log();
        pulse_start(c);
        repeat (10) tick();
        pulse_start(dummy);   // busy: must be ignored
        wait_done(1);
        total++;
        if (fs_cyc.size() !== 4 || ws_cyc.size() !== 4 || ct_cyc.size() !== 4 || cs_cyc.size() !== 4) begin
            bad++; $display("FAIL frame_counts: fetch=%0d ct=%0d cs=%0d ws=%0d want 4 each",
                fs_cyc.size(), ct_cyc.size(), cs_cyc.size(), ws_cyc.size());
        end
        total++;
        if (done_cyc.size() !== 1) begin
            bad++; $display("FAIL frame_done_count: got %0d want 1", done_cyc.size());
        end
        if (fs_cyc.size() == 4 && ws_cyc.size() == 4 && done_cyc.size() >= 1) begin
            total++;
            if (fs_cyc[0] !== c + 1) begin
                bad++; $display("FAIL start_latency: fetch_start at %0d want %0d", fs_cyc[0], c + 1);
            end
            total++;
            if (fs_cyc[1] - fs_cyc[0] !== 15) begin
                bad++; $display("FAIL slot_period: got %0d want 15", fs_cyc[1] - fs_cyc[0]);
            end
            total++;
            if (done_cyc[0] !== c + 76) begin
                bad++; $display("FAIL done_time: got %0d want %0d", done_cyc[0], c + 76);
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (fs_idx[i] !== exp_idx(i)) begin
                    bad++; $display("FAIL fetch_idx[%0d]: got %h want %h", i, fs_idx[i], exp_idx(i));
                end
                total++;
                if (ws_idx[i] !== exp_idx(i)) begin
                    bad++; $display("FAIL ws_idx[%0d]: got %h want %h", i, ws_idx[i], exp_idx(i));
                end
            end
        end
    endtask

    task automatic test_slot_edges();
        int c;
        clear_log();
        pulse_start(c);
        wait_done(1);
        if (fs_cyc.size() == 4 && ct_cyc.size() == 4 && cs_cyc.size() == 4 && ws_cyc.size() == 4) begin
            total++;
            if (cs_cyc[0] !== fs_cyc[1] || ws_cyc[0] !== ct_cyc[1]) begin
                bad++; $display("FAIL slot0_no_cs_ws: cs0=%0d ws0=%0d want %0d %0d",
                    cs_cyc[0], ws_cyc[0], fs_cyc[1], ct_cyc[1]);
            end
            total++;
            if (cs_cyc[3] !== fs_cyc[3] + 15 || ws_cyc[3] !== ct_cyc[3] + 15) begin
                bad++; $display("FAIL slot4_cs_ws_only: cs3=%0d ws3=%0d want %0d %0d",
                    cs_cyc[3], ws_cyc[3], fs_cyc[3] + 15, ct_cyc[3] + 15);
            end
        end else begin
            total++; bad++;
            $display("FAIL slot_edges_counts: fetch=%0d ct=%0d cs=%0d ws=%0d want 4 each",
                fs_cyc.size(), ct_cyc.size(), cs_cyc.size(), ws_cyc.size());
        end
    endtask

    task automatic test_phase_wait();
        int c;
        eng_dly[0] = 3;
        eng_dly[2] = 20;
        clear_log();
        pulse_start(c);
        wait_done(1);
        if (fs_cyc.size() >= 2 && ct_cyc.size() >= 2) begin
            total++;
            if (ct_cyc[0] - fs_cyc[0] !== 5) begin
                bad++; $display("FAIL phase_a_fetch_only: got %0d want 5", ct_cyc[0] - fs_cyc[0]);
            end
            total++;
            if (ct_cyc[1] - fs_cyc[1] !== 22) begin
                bad++; $display("FAIL phase_a_waits_cs: got %0d want 22", ct_cyc[1] - fs_cyc[1]);
            end
        end else begin
            total++; bad++;
            $display("FAIL phase_wait_counts: fetch=%0d ct=%0d", fs_cyc.size(), ct_cyc.size());
        end
        eng_dly[0] = 5;
        eng_dly[2] = 5;
    endtask

    task automatic test_stale_finish();
        int c;
        eng_dly[0]   = 20;
        eng_force[0] = 1'b1;   // level left over from a previous run
        tick();
        clear_log();
        pulse_start(c);        // now in launch cycle
        tick();                // launch+1
        tick();                // launch+2
        eng_force[0] = 1'b0;
        wait_done(1);
        total++;
        if (fs_cyc.size() < 1 || ct_cyc.size() < 1) begin
            bad++; $display("FAIL stale_counts: fetch=%0d ct=%0d", fs_cyc.size(), ct_cyc.size());
        end else if (ct_cyc[0] - fs_cyc[0] !== 22) begin
            bad++; $display("FAIL stale_finish_masked: ct_start after %0d want 22", ct_cyc[0] - fs_cyc[0]);
        end
        total++;
        if (done_cyc.size() !== 1) begin
            bad++; $display("FAIL stale_done: got %0d want 1", done_cyc.size());
        end
        eng_dly[0] = 5;
    endtask

    task automatic test_owner();
        int c;
        int n;
        clear_log();
        pulse_start(c);
        tick();
        tick();   // launch+2, fetch active
        ifc.fetch_sram_address = 18'h00abc;
        ifc.fetch_sram_we_n    = 1'b1;
        ifc.ws_sram_address    = 18'h12345;
        ifc.ws_sram_we_n       = 1'b0;
        ifc.ws_sram_write_data = 16'hbeef;
        #1;
        total++;
        if ({ifc.SRAM_we_n, ifc.SRAM_address, ifc.SRAM_write_data} !== {1'b1, 18'h00abc, 16'h0}) begin
            bad++; $display("FAIL owner_fetch: got we_n=%b addr=%h data=%h want 1/00abc/0000",
                ifc.SRAM_we_n, ifc.SRAM_address, ifc.SRAM_write_data);
        end
        n = 0;
        while (ifc.ws_start !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tick();   // one cycle into write phase
        total++;
        if ({ifc.SRAM_we_n, ifc.SRAM_address, ifc.SRAM_write_data} !== {1'b0, 18'h12345, 16'hbeef}) begin
            bad++; $display("FAIL owner_write: got we_n=%b addr=%h data=%h want 0/12345/beef",
                ifc.SRAM_we_n, ifc.SRAM_address, ifc.SRAM_write_data);
        end
        ifc.ws_sram_address = 18'h00f0f;
        #1;
        total++;
        if (ifc.SRAM_address !== 18'h00f0f) begin
            bad++; $display("FAIL owner_write_same_cycle: got %h want 00f0f", ifc.SRAM_address);
        end
        ifc.ws_sram_address = 18'h12345;
        wait_done(1);
        total++;
        if ({ifc.SRAM_we_n, ifc.SRAM_address} !== {1'b1, 18'h0}) begin
            bad++; $display("FAIL owner_none_idle: got we_n=%b addr=%h want 1/0",
                ifc.SRAM_we_n, ifc.SRAM_address);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int c;
        int n;
        clear_log();
        pulse_start(c);
        n = 0;
        while (ifc.done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (ifc.done !== 1'b0) begin
            bad++; $display("FAIL done_one_cycle: got %b want 0", ifc.done);
        end
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        total++;
        if (ifc.fetch_start !== 1'b1 || {ifc.fetch_plane, ifc.fetch_row, ifc.fetch_col} !== 13'h0) begin
            bad++; $display("FAIL back_to_back_start: got fetch_start=%b idx=%h want 1/0000",
                ifc.fetch_start, {ifc.fetch_plane, ifc.fetch_row, ifc.fetch_col});
        end
        wait_done(2);
        total++;
        if (done_cyc.size() !== 2 || fs_cyc.size() !== 8) begin
            bad++; $display("FAIL back_to_back_runs: done=%0d fetch=%0d want 2 8",
                done_cyc.size(), fs_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        int c;
        int n;
        clear_log();
        pulse_start(c);
        n = 0;
        while (ct_cyc.size() < 2 && n < 500) begin
            tick();
            n++;
        end
        tick();
        tick();   // phase B of slot 1, write engine owns SRAM
        ifc.ws_sram_address = 18'h12345;
        ifc.ws_sram_we_n    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({ifc.fetch_start, ifc.ct_start, ifc.cs_start, ifc.ws_start, ifc.done} !== 5'b0 ||
            {ifc.fetch_plane, ifc.fetch_row, ifc.fetch_col, ifc.ws_plane, ifc.ws_row, ifc.ws_col} !== 26'h0) begin
            bad++; $display("FAIL mid_reset_outputs: pulses=%b fetch=%h ws=%h want 0",
                {ifc.fetch_start, ifc.ct_start, ifc.cs_start, ifc.ws_start, ifc.done},
                {ifc.fetch_plane, ifc.fetch_row, ifc.fetch_col}, {ifc.ws_plane, ifc.ws_row, ifc.ws_col});
        end
        total++;
        if ({ifc.SRAM_we_n, ifc.SRAM_address} !== {1'b1, 18'h0} || dut.state !== ST_IDLE) begin
            bad++; $display("FAIL mid_reset_sram_state: we_n=%b addr=%h state=%0d want 1/0/%0d",
                ifc.SRAM_we_n, ifc.SRAM_address, dut.state, ST_IDLE);
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
        clear_log();
        pulse_start(c);
        wait_done(1);
        total++;
        if (fs_cyc.size() !== 4 || done_cyc.size() !== 1) begin
            bad++; $display("FAIL restart_counts: fetch=%0d done=%0d want 4 1", fs_cyc.size(), done_cyc.size());
        end else if (fs_idx[0] !== 13'h0 || fs_idx[1] !== 13'h1) begin
            bad++; $display("FAIL restart_block0: idx0=%h idx1=%h want 0000 0001", fs_idx[0], fs_idx[1]);
        end
    endtask

    initial begin
        reset     = 1'b1;
        ifc.start = 1'b0;
        eng_force = '0;
        eng_dly   = '{5, 5, 5, 5};
        idle_inputs();
        test_reset();
        test_frame();
        test_slot_edges();
        test_phase_wait();
        test_stale_finish();
        test_owner();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/m2_block_scheduler.md
# m2_block_scheduler

Top-level sequencer for the IDCT decode stage. It walks every 8x8 block of the Y, U and V planes. For each block it issues start/finish handshakes to four engines: S' fetch, compute T, compute S, and S write. It overlaps block k's fetch and T computation with block k-1's S computation and write-back, and owns the single external SRAM port, multiplexing it between the fetch and write engines.

## Interface
Parameters:
- Y_COL_BLOCKS, 40, Y-plane blocks per row (320 px)
- UV_COL_BLOCKS, 20, U/V-plane blocks per row (160 px)
- ROW_BLOCKS, 30, block rows per plane (240 px)

Ports:
- clock  in  1  system clock; one clock domain, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle request to decode a full frame; ignored unless IDLE
- done  out  1  single-cycle pulse when the last block is written
- fetch_start / ct_start / cs_start / ws_start  out  1 each  single-cycle launch pulses to the engines
- fetch_finish / ct_finish / cs_finish / ws_finish  in  1 each  engine completion; pulse or level
- fetch_col, ws_col  out  6  column block index of the block being fetched / written
- fetch_row, ws_row  out  5  row block index
- fetch_plane, ws_plane  out  2  plane: 0=Y, 1=U, 2=V
- fetch_sram_address  in  18, fetch_sram_we_n  in  1  fetch engine's SRAM request
- ws_sram_address  in  18, ws_sram_we_n  in  1, ws_sram_write_data  in  16  write engine's SRAM request
- SRAM_address  out  18, SRAM_we_n  out  1, SRAM_write_data  out  16  to the SRAM controller

## Operation
- Block order: row-major within a plane, then Y, U, V. N = (Y_COL_BLOCKS + 2*UV_COL_BLOCKS) * ROW_BLOCKS, which is 2400 by default.
- A run is N+1 slots. Each slot has phase A, then phase B.
  - Phase A: fetch(k) for k<N, and compute S(k-1) for k≥1.
  - Phase B: compute T(k) for k<N, and write S(k-1) for k≥1.
- States:
  - IDLE: on start, go to A_LAUNCH.
  - A_LAUNCH: pulse the applicable phase-A starts, set owner, clear flags; go to A_WAIT.
  - A_WAIT: when all launched flags are set, go to B_LAUNCH.
  - B_LAUNCH / B_WAIT: the same for phase B.
  - ADVANCE: if k==N, go to DONE; otherwise increment k and update indices, then go to A_LAUNCH.
  - DONE: pulse done, go to IDLE.
- Finish flags are sticky per engine and cleared in the launch cycle. A finish input is sampled only from launch+2 onward, which masks a finish level left over from the previous run.
- Engines not launched in a phase count as finished.
- Index counters:
  - The fetch index wraps col at the plane width, then row at ROW_BLOCKS, then advances plane.
  - The ws_* indices are the fetch indices delayed by one block and are loaded in ADVANCE.
  - Widths: col 6b, row 5b, k 12b, all unsigned. There is no arithmetic beyond increment and compare.
- SRAM owner register:
  - FETCH during phase A while fetch(k) is active.
  - WRITE during phase B while write(k-1) is active.
  - NONE otherwise.
- SRAM mux is combinational from owner. NONE drives SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0. Fetch never writes: its data path is forced to 0.

## Timing
- Reset values:
  - All start pulses 0, done 0.
  - All index outputs 0, owner NONE.
  - SRAM_we_n 1, SRAM_address 0, SRAM_write_data 0.
  - State IDLE.
- The start→fetch_start pulse has 1-cycle latency. Phase transitions occur 1 cycle after the last flag is set.
- The mux adds 0 cycles to engine SRAM requests.
- Simultaneous finishes in a phase are both captured. Finish arriving in launch or launch+1 is ignored.
- start while busy is ignored. Reset mid-run aborts immediately to reset values; engines are not notified.
- The done pulse is exactly 1 cycle. A new start is accepted in the cycle after done.

## Structure
- Shared package (with other decode-stage types): m2_sched_state_type enum, sram_owner_type enum {OWNER_NONE, OWNER_FETCH, OWNER_WRITE}, plane codes, and the block-count defaults.
- Sub-module: block_index_counter (col/row/plane wrap, parameterised widths). It is instantiated for the fetch side; the ws side is a register copy.
- Total target is roughly 250 lines of RTL.

## Test plan
- Params Y_COL_BLOCKS=2, UV_COL_BLOCKS=1, ROW_BLOCKS=1 (N=4), with engines that finish 5 cycles after start:
  - Expect 4 fetch_start and 4 ws_start pulses.
  - Fetch indices (0,0,Y), (1,0,Y), (0,0,U), (0,0,V); ws_* lag by one block.
  - done pulses once.
- Same config: check slot 0 has no cs_start/ws_start and slot 4 has no fetch_start/ct_start.
- Phase A with fetch finishing at cycle 3 and cs at cycle 20 → B_LAUNCH only after cycle 20.
- Finish held high from a prior run → the launch+0/+1 samples are ignored; the phase waits for finish at launch+2 or later.
- Owner checks:
  - While owner is FETCH, ws_sram_we_n=0 must not reach SRAM (SRAM_we_n=1).
  - While owner is WRITE, ws_sram_address=18'h12345 with we_n=0 appears on SRAM the same cycle.
- Assert reset mid phase B → next cycle all outputs at reset values, state IDLE; a fresh start restarts at block 0.
